// File: rtl/mt_d_cache_arbiter_if.sv
// Thread-side and cache-side signal bundle for mt_d_cache_arbiter.
// The arbiter connects through the slave modport and the EX-stage glue/cache through the master modport.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 26
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

interface mt_d_cache_arbiter_if #(
    parameter int THREADS    = 2,
    parameter int ADDR_WIDTH = `ADDR_WIDTH,
    parameter int DATA_WIDTH = `DATA_WIDTH
);
    logic [THREADS-1:0]    req_valid;
    logic [THREADS-1:0]    req_ready;
    logic [THREADS-1:0]    req_write;
    logic [ADDR_WIDTH-1:0] req_addr [THREADS];
    logic [DATA_WIDTH-1:0] req_data [THREADS];

    logic                  cache_valid;
    logic                  cache_write;
    logic [ADDR_WIDTH-1:0] cache_addr;
    logic [DATA_WIDTH-1:0] cache_data;
    logic                  cache_ready;

    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] resp_data;
    logic [THREADS-1:0]    rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  busy;

    modport slave (
        input  req_valid, req_write, req_addr, req_data,
        input  cache_ready, resp_valid, resp_data,
        output req_ready, cache_valid, cache_write, cache_addr, cache_data,
        output rsp_valid, rsp_data, busy
    );

    modport master (
        output req_valid, req_write, req_addr, req_data,
        output cache_ready, resp_valid, resp_data,
        input  req_ready, cache_valid, cache_write, cache_addr, cache_data,
        input  rsp_valid, rsp_data, busy
    );
endinterface

// File: rtl/mt_d_cache_arbiter.sv
// Round-robin d-cache request arbiter for THREADS hardware threads, one request in flight.
// Define MT_D_CACHE_ADDR_TAG_EN to replace the cache address MSBs with the issuing thread ID.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 26
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module mt_d_cache_arbiter #(
    parameter int THREADS    = 2,
    parameter int ADDR_WIDTH = `ADDR_WIDTH,
    parameter int DATA_WIDTH = `DATA_WIDTH
) (
    input logic                 clk,
    input logic                 rst,
    mt_d_cache_arbiter_if.slave bus
);
    localparam int TID_BITS = $clog2(THREADS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t                r_state;
    logic [THREADS-1:0]    r_held;
    logic [THREADS-1:0]    r_held_write;
    logic [ADDR_WIDTH-1:0] r_held_addr [THREADS];
    logic [DATA_WIDTH-1:0] r_held_data [THREADS];
    logic [TID_BITS-1:0]   r_grant;
    logic [TID_BITS-1:0]   r_last_grant;

    logic                  r_cache_valid;
    logic                  r_cache_write;
    logic [ADDR_WIDTH-1:0] r_cache_addr;
    logic [DATA_WIDTH-1:0] r_cache_data;
    logic [THREADS-1:0]    r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_data;

    logic [THREADS-1:0]    w_accept;
    logic [TID_BITS-1:0]   w_pick;
    logic [ADDR_WIDTH-1:0] w_issue_addr;

    assign w_accept = bus.req_valid & ~r_held;

    // Scan from farthest to nearest so the first held thread after last_grant wins.
    always_comb begin
        w_pick = r_last_grant;
        for (int i = THREADS; i >= 1; i--) begin
            if (r_held[r_last_grant + TID_BITS'(i)]) begin
                w_pick = r_last_grant + TID_BITS'(i);
            end
        end
    end

`ifdef MT_D_CACHE_ADDR_TAG_EN
    assign w_issue_addr = {w_pick, r_held_addr[w_pick][ADDR_WIDTH-TID_BITS-1:0]};
`else
    assign w_issue_addr = r_held_addr[w_pick];
`endif

    // NOTE: the payload registers carry no reset; r_held qualifies them, so only the flags need one.
    always_ff @(posedge clk) begin
        for (int t = 0; t < THREADS; t++) begin
            if (w_accept[t]) begin
                r_held_write[t] <= bus.req_write[t];
                r_held_addr[t]  <= bus.req_addr[t];
                r_held_data[t]  <= bus.req_data[t];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_held        <= '0;
            r_grant       <= '0;
            r_last_grant  <= TID_BITS'(THREADS - 1);
            r_cache_valid <= 1'b0;
            r_cache_write <= 1'b0;
            r_cache_addr  <= '0;
            r_cache_data  <= '0;
            r_rsp_valid   <= '0;
            r_rsp_data    <= '0;
        end else begin
            r_rsp_valid <= '0;
            r_held      <= r_held | w_accept;
            case (r_state)
                S_IDLE: begin
                    if (|r_held) begin
                        r_grant       <= w_pick;
                        r_cache_valid <= 1'b1;
                        r_cache_write <= r_held_write[w_pick];
                        r_cache_addr  <= w_issue_addr;
                        r_cache_data  <= r_held_data[w_pick];
                        r_state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (bus.cache_ready) begin
                        r_cache_valid <= 1'b0;
                        r_state       <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.resp_valid) begin
                        r_rsp_valid  <= THREADS'(1) << r_grant;
                        r_rsp_data   <= bus.resp_data;
                        r_held       <= (r_held | w_accept) & ~(THREADS'(1) << r_grant);
                        r_last_grant <= r_grant;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready   = ~r_held;
    assign bus.cache_valid = r_cache_valid;
    assign bus.cache_write = r_cache_write;
    assign bus.cache_addr  = r_cache_addr;
    assign bus.cache_data  = r_cache_data;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_data    = r_rsp_data;
    assign bus.busy        = (r_state != S_IDLE) || (|r_held);
endmodule

// File: tb/tb_mt_d_cache_arbiter.sv
// Self-checking bench for mt_d_cache_arbiter (THREADS=4, ADDR_WIDTH=26, DATA_WIDTH=32).
// A cache model pops expected requests from a scoreboard; a monitor pops expected responses.
module tb_mt_d_cache_arbiter;
    localparam int THREADS  = 4;
    localparam int TID_BITS = 2;
    localparam int AW       = 26;
    localparam int DW       = 32;

    typedef struct {
        int            tid;
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } req_t;

    typedef struct {
        int            tid;
        logic [DW-1:0] data;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mt_d_cache_arbiter_if #(.THREADS(THREADS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mt_d_cache_arbiter #(.THREADS(THREADS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    req_t exp_q[$];
    rsp_t rsp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    bit            model_en       = 1'b0;
    int            stall_cycles   = 0;
    logic          mdl_ready      = 1'b0;
    logic          mdl_resp_valid = 1'b0;
    logic [DW-1:0] mdl_resp_data  = '0;
    logic          man_ready      = 1'b0;
    logic          man_resp_valid = 1'b0;
    logic [DW-1:0] man_resp_data  = '0;

    assign bus.cache_ready = model_en ? mdl_ready      : man_ready;
    assign bus.resp_valid  = model_en ? mdl_resp_valid : man_resp_valid;
    assign bus.resp_data   = model_en ? mdl_resp_data  : man_resp_data;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [AW-1:0] exp_addr(input int tid, input logic [AW-1:0] a);
`ifdef MT_D_CACHE_ADDR_TAG_EN
        logic [TID_BITS-1:0] t;
        t = TID_BITS'(tid);
        return {t, a[AW-TID_BITS-1:0]};
`else
        return (tid >= 0) ? a : a;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input int tid, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req_valid[tid] = 1'b1;
        bus.req_write[tid] = w;
        bus.req_addr[tid]  = a;
        bus.req_data[tid]  = d;
    endtask

    task automatic push_req(input int tid, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        drive_req(tid, w, a, d);
        exp_q.push_back('{tid: tid, write: w, addr: a, data: d});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req_valid = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_cache_valid"}, 64'(bus.cache_valid), 64'(0));
        check({pfx, "_cache_write"}, 64'(bus.cache_write), 64'(0));
        check({pfx, "_cache_addr"},  64'(bus.cache_addr),  64'(0));
        check({pfx, "_cache_data"},  64'(bus.cache_data),  64'(0));
        check({pfx, "_rsp_valid"},   64'(bus.rsp_valid),   64'(0));
        check({pfx, "_rsp_data"},    64'(bus.rsp_data),    64'(0));
        check({pfx, "_busy"},        64'(bus.busy),        64'(0));
        check({pfx, "_req_ready"},   64'(bus.req_ready),   64'(4'hF));
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || rsp_q.size() != 0 || bus.busy) && n < 200) begin
            tick();
            n++;
        end
        check(tag, 64'(n < 200), 64'(1));
    endtask

    // Cache model: checks each presented request against the scoreboard, stalls, then responds.
    initial begin : cache_model
        req_t cur;
        int   stall_cnt;
        bit   accepted;
        cur       = '{tid: 0, write: 1'b0, addr: '0, data: '0};
        stall_cnt = 0;
        accepted  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!model_en) begin
                accepted       = 1'b0;
                stall_cnt      = 0;
                mdl_ready      = 1'b0;
                mdl_resp_valid = 1'b0;
            end else begin
                mdl_resp_valid = 1'b0;
                if (accepted) begin
                    accepted  = 1'b0;
                    mdl_ready = 1'b0;
                    check("c_drop_after_accept", 64'(bus.cache_valid), 64'(0));
                    mdl_resp_valid = 1'b1;
                    mdl_resp_data  = $urandom;
                    rsp_q.push_back('{tid: cur.tid, data: mdl_resp_data});
                end else if (bus.cache_valid) begin
                    if (stall_cnt == 0) begin
                        if (exp_q.size() == 0) check("c_unexpected", 64'(bus.cache_valid), 64'(0));
                        else cur = exp_q.pop_front();
                    end
                    check("c_write", 64'(bus.cache_write), 64'(cur.write));
                    check("c_addr",  64'(bus.cache_addr),  64'(exp_addr(cur.tid, cur.addr)));
                    check("c_data",  64'(bus.cache_data),  64'(cur.data));
                    if (stall_cnt == stall_cycles) begin
                        mdl_ready = 1'b1;
                        accepted  = 1'b1;
                        stall_cnt = 0;
                    end else begin
                        stall_cnt++;
                    end
                end else if (stall_cnt != 0) begin
                    check("c_valid_held", 64'(bus.cache_valid), 64'(1));
                    stall_cnt = 0;
                end
            end
        end
    end

    initial begin : rsp_monitor
        rsp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (bus.rsp_valid != '0) begin
                if (rsp_q.size() == 0) begin
                    check("rsp_unexpected", 64'(bus.rsp_valid), 64'(0));
                end else begin
                    e = rsp_q.pop_front();
                    check("rsp_onehot", 64'(bus.rsp_valid), 64'(1) << e.tid);
                    check("rsp_data",   64'(bus.rsp_data),  64'(e.data));
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int n;
        bus.req_valid = '0;
        bus.req_write = '0;
        for (int t = 0; t < THREADS; t++) begin
            bus.req_addr[t] = '0;
            bus.req_data[t] = '0;
        end

        // Reset values
        do_reset();
        check_reset_outputs("rst");

        // Single store from thread 1 at minimum latency
        model_en = 1'b0;
        drive_req(1, 1'b1, AW'('h10), DW'('hAB));
        tick();
        bus.req_valid = '0;
        check("t1_c1_req_ready", 64'(bus.req_ready), 64'(4'b1101));
        check("t1_c1_cache_valid", 64'(bus.cache_valid), 64'(0));
        check("t1_c1_busy", 64'(bus.busy), 64'(1));
        tick();
        check("t1_c2_cache_valid", 64'(bus.cache_valid), 64'(1));
        check("t1_c2_cache_write", 64'(bus.cache_write), 64'(1));
        check("t1_c2_cache_addr",  64'(bus.cache_addr),  64'(exp_addr(1, AW'('h10))));
        check("t1_c2_cache_data",  64'(bus.cache_data),  64'('hAB));
        man_ready = 1'b1;
        tick();
        man_ready = 1'b0;
        check("t1_c3_cache_valid", 64'(bus.cache_valid), 64'(0));
        man_resp_valid = 1'b1;
        man_resp_data  = 32'h1234_5678;
        rsp_q.push_back('{tid: 1, data: 32'h1234_5678});
        tick();
        man_resp_valid = 1'b0;
        check("t1_c4_rsp_valid", 64'(bus.rsp_valid), 64'(4'b0010));
        check("t1_c4_rsp_data",  64'(bus.rsp_data),  64'(32'h1234_5678));
        tick();
        check("t1_c5_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        check("t1_c5_req_ready", 64'(bus.req_ready), 64'(4'hF));
        check("t1_c5_busy",      64'(bus.busy),      64'(0));

        // All four threads at once, twice: grants must rotate 0,1,2,3 both rounds
        do_reset();
        model_en = 1'b1;
        for (int r = 0; r < 2; r++) begin
            stall_cycles = r;
            for (int t = 0; t < THREADS; t++) begin
                push_req(t, 1'(r & t), AW'((t << 8) | $urandom_range(0, 255)), $urandom);
            end
            tick();
            bus.req_valid = '0;
            wait_drain("t2_drain");
        end
        stall_cycles = 0;

        // Cache stalls five cycles in ISSUE
        do_reset();
        stall_cycles = 5;
        push_req(2, 1'b1, AW'('h3F_FFFF), 32'hDEAD_BEEF);
        tick();
        bus.req_valid = '0;
        wait_drain("t3_drain");
        stall_cycles = 0;

        // Thread 0 re-requests right after completing while thread 1 is still held
        do_reset();
        push_req(0, 1'b0, AW'('h100), 32'h0);
        push_req(1, 1'b1, AW'('h200), 32'h1111);
        tick();
        bus.req_valid = '0;
        n = 0;
        while (!bus.rsp_valid[0] && n < 50) begin
            tick();
            n++;
        end
        check("t4_first_rsp_seen", 64'(n < 50), 64'(1));
        check("t4_ready0", 64'(bus.req_ready[0]), 64'(1));
        check("t4_held1",  64'(bus.req_ready[1]), 64'(0));
        push_req(0, 1'b0, AW'('h300), 32'h2222);
        tick();
        bus.req_valid = '0;
        wait_drain("t4_drain");

        // resp_valid while IDLE is ignored
        model_en = 1'b0;
        tick();
        man_resp_valid = 1'b1;
        man_resp_data  = 32'hCAFE_F00D;
        tick();
        man_resp_valid = 1'b0;
        check("t5_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        check("t5_busy", 64'(bus.busy), 64'(0));
        check("t5_cache_valid", 64'(bus.cache_valid), 64'(0));
        tick();
        check("t5_rsp_valid_next", 64'(bus.rsp_valid), 64'(0));
        check("t5_req_ready", 64'(bus.req_ready), 64'(4'hF));

        // Reset during WAIT drops the request; the late response is ignored
        drive_req(3, 1'b0, AW'('h55), 32'h0);
        tick();
        bus.req_valid = '0;
        tick();
        check("t6_issue", 64'(bus.cache_valid), 64'(1));
        man_ready = 1'b1;
        tick();
        man_ready = 1'b0;
        check("t6_wait_busy", 64'(bus.busy), 64'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_outputs("t6");
        man_resp_valid = 1'b1;
        man_resp_data  = 32'h7777_7777;
        tick();
        man_resp_valid = 1'b0;
        check("t6_late_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        check("t6_late_busy", 64'(bus.busy), 64'(0));
        tick();
        check("t6_late_rsp_valid_next", 64'(bus.rsp_valid), 64'(0));
        check("t6_late_cache_valid", 64'(bus.cache_valid), 64'(0));

        check("end_exp_q_empty", 64'(exp_q.size()), 64'(0));
        check("end_rsp_q_empty", 64'(rsp_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
